// File: rtl/dcache_responder_if.sv
// CPU data-access handshake plus backing word-memory port for dcache_responder.
// The slave modport is the cache; the master modport is the CPU/memory side.
interface dcache_responder_if;
  logic        read;
  logic [3:0]  write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        data_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  read, write, addr, wdata, mem_rdata, mem_ack,
    output rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output read, write, addr, wdata, mem_rdata, mem_ack,
    input  rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache
// answering CPU loads/stores with a one-cycle data_ready pulse.
module dcache_responder #(
  parameter int INDEX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  dcache_responder_if.slave bus
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MEM_RD, S_MEM_WR, S_RESP} state_t;

  state_t                r_state;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_line [LINES];
  logic [31:0]           r_rdata;
  logic                  r_data_ready;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [31:0]           r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_wstrb;

  logic [INDEX_BITS-1:0] w_req_idx;
  logic [TAG_BITS-1:0]   w_req_tag;
  logic                  w_req_hit;
  logic                  w_store;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_unused;

  // Byte-lane merge of store data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  assign w_req_idx  = bus.addr[INDEX_BITS+1:2];
  assign w_req_tag  = bus.addr[31:INDEX_BITS+2];
  assign w_req_hit  = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_store    = (bus.write != 4'b0000);
  // The outstanding miss address selects the line to fill.
  assign w_fill_idx = r_mem_addr[INDEX_BITS+1:2];
  assign w_fill_tag = r_mem_addr[31:INDEX_BITS+2];
  // Byte-offset bits play no role in a word cache.
  assign w_unused   = &{1'b0, bus.addr[1:0], r_mem_addr[1:0]};

  assign bus.rdata      = r_rdata;
  assign bus.data_ready = r_data_ready;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wstrb  = r_mem_wstrb;

  // Tag/data arrays: store-hit merge in IDLE, line fill on read ack; never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_IDLE && w_store && w_req_hit) begin
        r_line[w_req_idx] <= merge_bytes(r_line[w_req_idx], bus.wdata, bus.write);
      end else if (r_state == S_MEM_RD && bus.mem_ack) begin
        r_line[w_fill_idx] <= bus.mem_rdata;
        r_tag[w_fill_idx]  <= w_fill_tag;
      end
    end
  end

  // Control FSM with registered outputs; stores win over loads in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_rdata      <= '0;
      r_data_ready <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= '0;
    end else begin
      r_data_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_store) begin
            r_mem_addr  <= {bus.addr[31:2], 2'b00};
            r_mem_wdata <= bus.wdata;
            r_mem_wstrb <= bus.write;
            r_mem_we    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_state     <= S_MEM_WR;
          end else if (bus.read) begin
            if (w_req_hit) begin
              r_rdata      <= r_line[w_req_idx];
              r_data_ready <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mem_addr <= {bus.addr[31:2], 2'b00};
              r_mem_we   <= 1'b0;
              r_mem_req  <= 1'b1;
              r_state    <= S_MEM_RD;
            end
          end
        end
        S_MEM_RD: begin
          if (bus.mem_ack) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_rdata             <= bus.mem_rdata;
            r_mem_req           <= 1'b0;
            r_data_ready        <= 1'b1;
            r_state             <= S_RESP;
          end
        end
        S_MEM_WR: begin
          if (bus.mem_ack) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_data_ready <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        // One-cycle response; the held request is not resampled here.
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: cold miss, hit, store merge, eviction,
// no-write-allocate, read+write priority and reset during a miss.
module tb_dcache_responder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  dcache_responder_if bus();

  dcache_responder #(.INDEX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations collected by run_txn for the calling test.
  logic        t_req;
  logic        t_rdreq;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;
  logic        t_hold_ok;
  int          t_dr_count;
  int          t_dr_cycle;
  logic [31:0] t_rdata;

  // Present one request, act as memory (ack dly cycles after mem_req), record what happens.
  task automatic run_txn(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] md, input int dly);
    int req_cnt;
    req_cnt = 0;
    t_req = 0; t_rdreq = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_wstrb = 0;
    t_hold_ok = 1; t_dr_count = 0; t_dr_cycle = -1; t_rdata = 0;
    bus.read = rd; bus.write = wr; bus.addr = a; bus.wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (req_cnt == 0) begin
          t_req = 1; t_we = bus.mem_we; t_addr = bus.mem_addr;
          t_wdata = bus.mem_wdata; t_wstrb = bus.mem_wstrb;
        end else if (bus.mem_addr !== t_addr || bus.mem_we !== t_we) begin
          t_hold_ok = 0;
        end
        if (!bus.mem_we) t_rdreq = 1;
        req_cnt++;
        if (req_cnt == dly) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = md;
        end
      end
      if (bus.data_ready) begin
        t_dr_count++;
        if (t_dr_cycle < 0) begin
          t_dr_cycle = c;
          t_rdata = bus.rdata;
        end
        bus.read = 1'b0;
        bus.write = 4'b0000;
      end
      if (t_dr_cycle >= 0 && c >= t_dr_cycle + 3) break;
    end
    bus.read = 1'b0;
    bus.write = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%b want=0", bus.data_ready); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0) begin
      bad++; $display("FAIL reset_mem_bus got=%h/%h/%h want=0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    run_txn(1'b1, 4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    total++; if (t_req !== 1'b1 || t_we !== 1'b0) begin bad++; $display("FAIL cold_req got req=%b we=%b want 1/0", t_req, t_we); end
    total++; if (t_addr !== 32'h100) begin bad++; $display("FAIL cold_addr got=%h want=00000100", t_addr); end
    total++; if (t_hold_ok !== 1'b1) begin bad++; $display("FAIL cold_hold got=%b want=1", t_hold_ok); end
    total++; if (t_dr_cycle != 4) begin bad++; $display("FAIL cold_latency got=%0d want=4", t_dr_cycle); end
    total++; if (t_dr_count != 1) begin bad++; $display("FAIL cold_dr_count got=%0d want=1", t_dr_count); end
    total++; if (t_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cold_rdata got=%h want=deadbeef", t_rdata); end
  endtask

  task automatic test_load_hit();
    run_txn(1'b1, 4'b0000, 32'h100, 32'h0, 32'h0, 1);
    total++; if (t_req !== 1'b0) begin bad++; $display("FAIL hit_no_mem got=%b want=0", t_req); end
    total++; if (t_dr_cycle != 1) begin bad++; $display("FAIL hit_latency got=%0d want=1", t_dr_cycle); end
    total++; if (t_dr_count != 1) begin bad++; $display("FAIL hit_dr_count got=%0d want=1", t_dr_count); end
    total++; if (t_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hit_rdata got=%h want=deadbeef", t_rdata); end
  endtask

  task automatic test_store_hit();
    run_txn(1'b0, 4'b0010, 32'h101, 32'h0000AA00, 32'h0, 2);
    total++; if (t_req !== 1'b1 || t_we !== 1'b1) begin bad++; $display("FAIL st_req got req=%b we=%b want 1/1", t_req, t_we); end
    total++; if (t_addr !== 32'h100) begin bad++; $display("FAIL st_addr got=%h want=00000100", t_addr); end
    total++; if (t_wstrb !== 4'b0010) begin bad++; $display("FAIL st_wstrb got=%b want=0010", t_wstrb); end
    total++; if (t_wdata !== 32'h0000AA00) begin bad++; $display("FAIL st_wdata got=%h want=0000aa00", t_wdata); end
    total++; if (t_dr_cycle != 3) begin bad++; $display("FAIL st_latency got=%0d want=3", t_dr_cycle); end
    total++; if (t_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_rdata_hold got=%h want=deadbeef", t_rdata); end
    run_txn(1'b1, 4'b0000, 32'h100, 32'h0, 32'h0, 1);
    total++; if (t_req !== 1'b0) begin bad++; $display("FAIL reload_no_mem got=%b want=0", t_req); end
    total++; if (t_rdata !== 32'hDEADAAEF) begin bad++; $display("FAIL reload_rdata got=%h want=deadaaef", t_rdata); end
  endtask

  task automatic test_eviction();
    run_txn(1'b1, 4'b0000, 32'h140, 32'h0, 32'h11112222, 1);
    total++; if (t_req !== 1'b1 || t_addr !== 32'h140) begin bad++; $display("FAIL evict_miss got req=%b addr=%h want 1/00000140", t_req, t_addr); end
    total++; if (t_rdata !== 32'h11112222) begin bad++; $display("FAIL evict_rdata got=%h want=11112222", t_rdata); end
    run_txn(1'b1, 4'b0000, 32'h100, 32'h0, 32'hDEADAAEF, 1);
    total++; if (t_req !== 1'b1 || t_we !== 1'b0) begin bad++; $display("FAIL evict_remiss got req=%b we=%b want 1/0", t_req, t_we); end
    run_txn(1'b0, 4'b1111, 32'h200, 32'hCAFEF00D, 32'h0, 1);
    total++; if (t_we !== 1'b1 || t_addr !== 32'h200) begin bad++; $display("FAIL nwa_store got we=%b addr=%h want 1/00000200", t_we, t_addr); end
    run_txn(1'b1, 4'b0000, 32'h200, 32'h0, 32'hCAFEF00D, 1);
    total++; if (t_req !== 1'b1 || t_we !== 1'b0) begin bad++; $display("FAIL nwa_read_miss got req=%b we=%b want 1/0", t_req, t_we); end
    total++; if (t_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL nwa_rdata got=%h want=cafef00d", t_rdata); end
  endtask

  task automatic test_read_write_same();
    run_txn(1'b1, 4'b0001, 32'h100, 32'h00000055, 32'h0, 2);
    total++; if (t_we !== 1'b1) begin bad++; $display("FAIL rw_we got=%b want=1", t_we); end
    total++; if (t_rdreq !== 1'b0) begin bad++; $display("FAIL rw_no_read got=%b want=0", t_rdreq); end
    total++; if (t_dr_count != 1) begin bad++; $display("FAIL rw_dr_count got=%0d want=1", t_dr_count); end
    total++; if (t_wstrb !== 4'b0001) begin bad++; $display("FAIL rw_wstrb got=%b want=0001", t_wstrb); end
  endtask

  task automatic test_reset_mid_miss();
    int seen;
    int drs;
    seen = 0;
    bus.read = 1'b1; bus.write = 4'b0000; bus.addr = 32'h300;
    for (int c = 0; c < 5 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (bus.mem_req) seen = 1;
    end
    total++; if (seen != 1) begin bad++; $display("FAIL rmm_enter got=%0d want=1", seen); end
    rst = 1'b0; bus.read = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmm_req got=%b want=0", bus.mem_req); end
    total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rmm_dr got=%b want=0", bus.data_ready); end
    rst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    drs = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.data_ready) drs++;
    end
    total++; if (drs != 0) begin bad++; $display("FAIL rmm_stray_ack got=%0d want=0", drs); end
    run_txn(1'b1, 4'b0000, 32'h200, 32'h0, 32'h12345678, 1);
    total++; if (t_req !== 1'b1) begin bad++; $display("FAIL rmm_valid_clear got=%b want=1", t_req); end
    total++; if (t_rdata !== 32'h12345678) begin bad++; $display("FAIL rmm_rdata got=%h want=12345678", t_rdata); end
    run_txn(1'b1, 4'b0000, 32'h100, 32'h0, 32'hDEADAAEF, 1);
    total++; if (t_req !== 1'b1 || t_we !== 1'b0) begin bad++; $display("FAIL rmm_reload_miss got req=%b we=%b want 1/0", t_req, t_we); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.read = 1'b0; bus.write = 4'b0000; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
    test_reset();
    test_cold_miss();
    test_load_hit();
    test_store_hit();
    test_eviction();
    test_read_write_same();
    test_reset_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder for the CPU core's data-access handshake (read/write[3:0]/address/store data out, load data/data_ready in).
- Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache, backed by a simple req/ack word memory port.
- Answers each CPU request with a single-cycle data_ready pulse. The core holds its pipeline stalled until that pulse arrives.

Parameters:
INDEX_BITS, 4, number of line-index bits; the cache holds 2^INDEX_BITS lines, index = addr[INDEX_BITS+1:2]
TAG_BITS, 30-INDEX_BITS (derived, not overridable), tag = addr[31:INDEX_BITS+2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
read  in  1  CPU load request, level, held until data_ready
write  in  4  CPU store byte enables, level, held until data_ready; nonzero = store request
addr  in  32  CPU byte address; addr[1:0] ignored
wdata  in  32  CPU store data, lane-aligned
rdata  out  32  load data (full word), valid while data_ready=1
data_ready  out  1  one-cycle completion pulse
mem_req  out  1  backing-memory request, held until mem_ack
mem_we  out  1  1 = memory write, 0 = memory read
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  store data
mem_wstrb  out  4  store byte enables
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE. All valid bits clear.
  - rdata, data_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb all go to 0.
  - Tag/data arrays are not reset.
  - Reset mid-transaction abandons it. mem_req is low from the following cycle, and a late mem_ack is ignored.
- States: IDLE, MEM_RD, MEM_WR, RESP.
- IDLE samples the request every cycle:
  - write!=0 takes priority over read when both are asserted; read is ignored.
  - Store: if the line is valid with a matching tag, merge the enabled bytes into the cached word in this cycle.
  - Store, hit or miss: latch mem_addr/mem_wdata/mem_wstrb, set mem_we=1 and mem_req=1, go to MEM_WR.
  - Store miss: no allocate; valid/tag unchanged.
  - Load hit: latch the cached word into rdata, go to RESP. data_ready is high in the cycle after the request is first seen (1-cycle latency). No memory traffic.
  - Load miss: latch mem_addr, set mem_we=0 and mem_req=1, go to MEM_RD.
  - No request: stay in IDLE; outputs hold, data_ready=0.
- MEM_RD:
  - Hold mem_req/mem_addr until mem_ack.
  - On mem_ack: write mem_rdata into the line, set tag and valid (evicting any prior line), latch rdata=mem_rdata, drop mem_req, go to RESP.
- MEM_WR:
  - Hold mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb until mem_ack.
  - On mem_ack: drop mem_req and mem_we, go to RESP.
- RESP:
  - data_ready=1 for exactly this cycle, then unconditionally go to IDLE.
  - Request inputs are not sampled in RESP. This guarantees one bubble cycle and no double-acceptance of a held request.
- mem_ack while in IDLE or RESP is ignored.
- rdata holds its last value outside RESP. Store completions leave rdata unchanged.
- Minimum latencies: load hit 1 cycle to data_ready. Load miss and all stores take (cycles to mem_ack)+1.
- Memory transactions are never issued speculatively: at most one outstanding mem_req, and none in RESP or IDLE.

Test Plan:
- Cold load miss:
  - Stimulus: rst low 2 cycles, then read=1 addr=0x100; memory returns mem_ack+mem_rdata=0xDEADBEEF 3 cycles after mem_req.
  - Required: mem_req=1 and mem_we=0 with mem_addr=0x100 until the ack; data_ready pulses once the next cycle with rdata=0xDEADBEEF.
- Load hit:
  - Stimulus: repeat read 0x100.
  - Required: data_ready=1 exactly one cycle after the request, rdata=0xDEADBEEF, mem_req stays 0.
- Byte store hit then reload:
  - Stimulus: write=4'b0010 wdata=0x0000AA00 addr=0x101.
  - Required: mem write with mem_addr=0x100 and mem_wstrb=0010; data_ready the cycle after mem_ack.
  - Stimulus: read 0x100.
  - Required: hit with rdata=0xDEADAAEF.
- Conflict eviction and no-write-allocate:
  - Stimulus: read 0x140 (same index 0, different tag).
  - Required: miss, fill.
  - Stimulus: read 0x100.
  - Required: misses again.
  - Stimulus: write 4'b1111 to 0x200, then read 0x200.
  - Required: the read is a miss (mem_req, mem_we=0).
- Simultaneous read+write:
  - Stimulus: read=1 and write=4'b0001 together at 0x100.
  - Required: a memory write is issued (mem_we=1), no memory read, one data_ready.
- Reset mid-miss:
  - Stimulus: assert rst low while in MEM_RD.
  - Required: next cycle mem_req=0 and data_ready=0; a stray mem_ack afterward causes no data_ready.
  - Stimulus: read 0x100 afterward.
  - Required: miss, since valid bits were cleared.
